uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver consuming the 16x-oversample tick produced by the baud rate generator (one-clock `tick` pulse, 16 per bit period).
- Synchronises the serial `rx` line and detects the start bit with mid-bit validation.
- Samples data bits LSB first at bit centres, checks the stop bit, and presents the byte with a one-clock `rx_done` strobe.
- Sits between the serial pin and the BIP host-interface logic that consumes received bytes.

Parameters:
- DATA_BITS, 8, number of data bits per frame (1..16).
- SB_TICKS, 16, number of ticks spanning the stop bit (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- tick  input  1  16x-oversample strobe, one clk wide; state advances only on cycles where tick=1.
- rx  input  1  asynchronous serial line, idle high.
- dout  output  DATA_BITS  last received data word.
- rx_done  output  1  one-clk pulse, frame complete, dout valid.
- frame_err  output  1  stop bit sampled low on the last completed frame.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE; tick counter s=0; bit counter n=0; shift register b=0.
  - dout=0, rx_done=0, frame_err=0.
  - Both synchroniser flops=1.
- Input path: rx passes through a 2-flop synchroniser; the FSM uses the synchronised value rx_s only, so there are 2 clk of latency from the pin.
- Counters: s is 5 bits, wide enough for SB_TICKS-1 up to 31. n is $clog2(DATA_BITS) bits, minimum 1. Both are plain counters with no wrap beyond the stated compare values.
- FSM states and transitions (IDLE responds every clk; all other states act only when tick=1 and hold otherwise):
  - IDLE: rx_s=0 → START, s=0. No tick required.
  - START: if s==7 then rx_s=0 → DATA with s=0, n=0; rx_s=1 → IDLE (glitch rejected, no outputs change). Else s=s+1.
  - DATA: if s==15 then s=0, b={rx_s, b[DATA_BITS-1:1]}, and n==DATA_BITS-1 → STOP (PARITY if enabled), else n=n+1. Else s=s+1.
  - STOP: if s==SB_TICKS-1 → IDLE, and in that same clk register dout<=b, frame_err<=~rx_s, rx_done<=1. Else s=s+1.
- Output rules:
  - rx_done is high for exactly one clk, the clk after the final STOP tick; it coincides with the dout/frame_err update.
  - dout and frame_err hold until the next frame completes.
  - A frame with a bad stop bit still updates dout and still pulses rx_done.
- Timing:
  - Data bit k is sampled at 16*(k+1)+8 ticks after the detected falling edge, i.e. at the bit centre.
  - A new start bit is accepted from the clk after STOP→IDLE, so back-to-back frames are supported.
- rx during non-tick cycles is ignored except for the IDLE falling-edge detection.
- Reset mid-frame aborts the frame immediately with no rx_done. Reception resumes at the next falling edge after reset deasserts.
- tick held permanently at 1 is legal: the FSM then samples at clk rate.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP: on tick with s==15, s=0, p<=rx_s, → STOP.
  - Adds port parity_err (output, 1 bit, reset 0), checked as even parity.
  - On the rx_done clk, parity_err<=(^b)^p. It holds until the next frame completes.
  - Frame length grows by 16 ticks.
- UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port; DATA goes directly to STOP.

Test Plan:
- Nominal frame: tick every 4 clk; drive 0xA5 LSB first with a start bit and stop=1 → exactly one rx_done pulse, dout=0xA5, frame_err=0, FSM back in IDLE.
- Glitch rejection: rx low for 4 ticks, then high → no rx_done, dout unchanged (0x00 after reset), FSM returns to IDLE; a following 0x3C frame is received correctly.
- Framing error: frame 0x81 with stop bit driven 0 → rx_done pulses, dout=0x81, frame_err=1; next good frame 0x7E → frame_err=0.
- Back-to-back: 0x00 then 0xFF with no idle gap → two rx_done pulses 160 ticks apart; dout=0x00, then 0xFF.
- Reset mid-frame: assert rst for 3 clk during data bit 4 of 0xC3 → dout=0, rx_done=0, frame_err=0 immediately; the subsequent frame 0x5A gives dout=0x5A.
- Parity (UART_RX_PARITY_EN): 0x01 with parity bit 1 → parity_err=0; 0x01 with parity bit 0 → parity_err=1; dout=0x01 both times.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver on a 16x-oversample tick: start-bit validation, LSB-first data, stop check.
// Optional even-parity stage and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [4:0]    S_LAST = 5'(SB_TICKS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  state_t                 state_r;
  logic [4:0]             s_r;
  logic [NW-1:0]          n_r;
  logic [DATA_BITS-1:0]   b_r;
  logic                   sync1_r;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   p_r;
`endif

  // Shift the new bit in at the MSB end so the first bit received ends up in bit 0.
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] v, input logic bit_in);
    logic [DATA_BITS-1:0] t;
    t = v >> 1;
    t[DATA_BITS-1] = bit_in;
    return t;
  endfunction

  function automatic logic xor_reduce(input logic [DATA_BITS-1:0] v);
    return ^v;
  endfunction

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Receive FSM with registered outputs; IDLE reacts every clk, other states only on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      s_r        <= 5'd0;
      n_r        <= '0;
      b_r        <= '0;
      dout       <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_r        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            s_r     <= 5'd0;
          end
        end
        START: begin
          if (tick) begin
            if (s_r == 5'd7) begin
              // A start bit still low at its centre is genuine; otherwise treat it as a glitch.
              if (!rx_s) begin
                state_r <= DATA;
                s_r     <= 5'd0;
                n_r     <= '0;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_r == 5'd15) begin
              s_r <= 5'd0;
              b_r <= shift_in(b_r, rx_s);
              if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end else begin
                n_r <= n_r + N_ONE;
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_r == 5'd15) begin
              s_r     <= 5'd0;
              p_r     <= rx_s;
              state_r <= STOP;
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s_r == S_LAST) begin
              state_r    <= IDLE;
              dout       <= b_r;
              frame_err  <= ~rx_s;
              rx_done    <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= xor_reduce(b_r) ^ p_r;
`endif
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= 5'd0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  logic unused_xr;
  assign unused_xr = xor_reduce(b_r);
`endif

endmodule
